modinv: RTL
===========

MODINV -- requirements
Module: modinv

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port A  input  12  operand, unsigned, 0..4095.
REQ-005 SHALL have port busy  output  1  high while exponentiation in progress.
REQ-006 SHALL have port done  output  1  one-cycle completion pulse.
REQ-007 SHALL have port R  output  12  result, A^-1 mod q, held until next accepted start.
REQ-008 SHALL have port err  output  1  operand congruent to 0 mod q; valid with done, held with R.

Function
REQ-009 SHALL compute R = A^(q-2) mod q, q = 3329, exponent 3327 = 1100_1111_1111b, i.e. the modular inverse for A != 0 mod q.
REQ-010 SHALL reduce A on acceptance: a = A-q if A >= q, else a = A (single conditional subtract, A < 2q always).
REQ-011 SHALL use states IDLE, SQR, MUL, DONE; an accepted start loads base = a, acc = 1, bit index = 11, enters SQR.
REQ-012 SHALL take exactly 2 cycles per modular multiply: cycle 1 registers the 24-bit product, cycle 2 writes the mod-q reduced value (0..3328) into acc.
REQ-013 SHALL in SQR compute acc = acc*acc, then MUL; in MUL compute acc = acc*base if exponent bit set, else acc*1 (constant time, no skipping).
REQ-014 SHALL after MUL decrement bit index and return to SQR, or enter DONE after bit 0.
REQ-015 SHALL give latency: start sampled at edge 0 -> done = 1 for the cycle following edge 49 (48 multiply cycles + 1).
REQ-016 SHALL in DONE assert done = 1, busy = 0, R = acc, err = (a == 0), then return to IDLE next edge.
REQ-017 SHALL hold busy = 1 exactly in SQR and MUL.
REQ-018 SHALL ignore start outside IDLE (including the DONE cycle); a back-to-back request needs start high in IDLE.
REQ-019 SHALL leave R and err unchanged from DONE until the next DONE.

Reset
REQ-020 SHALL on rst = 1 at a rising edge force IDLE, busy = 0, done = 0, R = 0, err = 0, acc = 0, product register = 0.
REQ-021 SHALL, if rst is high in any state (mid-operation included), abort without a done pulse; rst has priority over start.

Configuration
REQ-022 SHALL, with macro MODINV_EARLY_ZERO_EN defined, go from IDLE directly to DONE when a == 0: done at edge 1 after start, R = 0, err = 1, busy never high.
REQ-023 SHALL, without MODINV_EARLY_ZERO_EN, run the full 49-cycle sequence for a == 0, giving R = 0, err = 1.

Verification
REQ-024 SHALL cover: A = 2 -> R = 1665, err = 0, done exactly 49 cycles after start, busy high for 48 cycles.
REQ-025 SHALL cover: A = 17 -> R = 1175; A = 3328 -> R = 3328; A = 1 -> R = 1.
REQ-026 SHALL cover: A = 3330 (>= q) -> R = 1; A = 3329 and A = 0 -> R = 0, err = 1, latency 49 without macro, 1 with macro.
REQ-027 SHALL cover: start pulsed with A = 5 at cycle 10 of a run with A = 2 -> ignored, result 1665, no second done.
REQ-028 SHALL cover: rst asserted at cycle 20 of a run -> next cycle busy = 0, R = 0, no done; following start with A = 17 -> R = 1175 after 49 cycles.
REQ-029 SHALL cover: exhaustive sweep A = 1..3328 -> (A*R) mod 3329 == 1 for every result.

Source files
------------

// File: rtl/modinv.sv
// Modular inverse modulo q = 3329 by square-and-multiply exponentiation to q-2.
// Optional macro MODINV_EARLY_ZERO_EN: a zero operand skips straight to the completion pulse.
module modinv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] A,
  output logic        busy,
  output logic        done,
  output logic [11:0] R,
  output logic        err
);

  localparam logic [11:0] Q12       = 12'd3329;
  localparam logic [12:0] Q13       = 13'd3329;
  localparam logic [11:0] EXPONENT  = 12'hCFF;
  localparam logic [36:0] BARRETT_M = 37'd5039;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t      state_q;
  logic [11:0] acc_q;
  logic [11:0] base_q;
  logic [23:0] prod_q;
  logic [3:0]  bitIdx_q;
  logic        phase_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] R_q;
  logic        err_q;

  logic [11:0] aRed;
  logic [11:0] opB;
  logic [23:0] prodFull;
  logic [12:0] qHat;
  logic [12:0] qTimes;
  logic [12:0] rem;
  logic [11:0] reduced;

  // Barrett reduction of the registered product: the quotient estimate is at most
  // one short, so the remainder is below 2q and one conditional subtract finishes it.
  always_comb begin
    aRed     = (A >= Q12) ? (A - Q12) : A;
    opB      = 12'd1;
    if (state_q == SQR) begin
      opB = acc_q;
    end else if (EXPONENT[bitIdx_q]) begin
      opB = base_q;
    end
    prodFull = 24'(acc_q) * 24'(opB);
    qHat     = 13'((37'(prod_q) * BARRETT_M) >> 24);
    qTimes   = qHat * Q13;
    rem      = prod_q[12:0] - qTimes;
    reduced  = (rem >= Q13) ? 12'(rem - Q13) : rem[11:0];
  end

  // Each multiply spends phase 0 registering the product and phase 1 writing acc;
  // the done pulse is registered one cycle after DONE, so IDLE also refuses start
  // while that pulse is on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      prod_q   <= '0;
      bitIdx_q <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      R_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            base_q   <= aRed;
            acc_q    <= 12'd1;
            bitIdx_q <= 4'd11;
            phase_q  <= 1'b0;
`ifdef MODINV_EARLY_ZERO_EN
            if (aRed == 12'd0) begin
              state_q <= DONE;
            end else begin
              state_q <= SQR;
              busy_q  <= 1'b1;
            end
`else
            state_q <= SQR;
            busy_q  <= 1'b1;
`endif
          end
        end
        SQR, MUL: begin
          if (!phase_q) begin
            prod_q  <= prodFull;
            phase_q <= 1'b1;
          end else begin
            acc_q   <= reduced;
            phase_q <= 1'b0;
            if (state_q == SQR) begin
              state_q <= MUL;
            end else if (bitIdx_q == 4'd0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              bitIdx_q <= bitIdx_q - 4'd1;
              state_q  <= SQR;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          R_q     <= (base_q == 12'd0) ? 12'd0 : acc_q;
          err_q   <= (base_q == 12'd0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = R_q;
  assign err  = err_q;

endmodule
